// File: rtl/stage_pipe_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// flush, and a saturating stall counter. All outputs come straight from flops;
// in_ready is a registered copy of "not FULL" so it never depends on out_ready.
module stage_pipe_skid #(
  parameter int                 INST_W   = 32,
  parameter int                 PC_W     = 32,
  parameter logic [INST_W-1:0]  NOP_INST = 'h00000013,
  parameter logic [PC_W-1:0]    RESET_PC = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [PC_W-1:0]   pc_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [INST_W-1:0] m_inst_q, m_inst_d;
  logic [PC_W-1:0]   m_pc_q, m_pc_d;
  logic [INST_W-1:0] s_inst_q, s_inst_d;
  logic [PC_W-1:0]   s_pc_q, s_pc_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              in_fire, out_fire;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state, data movement and counter update; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    m_inst_d    = m_inst_q;
    m_pc_d      = m_pc_q;
    s_inst_d    = s_inst_q;
    s_pc_d      = s_pc_q;
    in_fire     = in_valid & in_ready_q;
    out_fire    = out_valid_q & out_ready;
    stall_cnt_d = (out_valid_q & ~out_ready) ? sat_inc(stall_cnt_q) : stall_cnt_q;

    if (flush) begin
      // Squash both slots; pc_out deliberately keeps its last value.
      state_d  = EMPTY;
      m_inst_d = NOP_INST;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d  = BUSY;
            m_inst_d = inst_in;
            m_pc_d   = pc_in;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            m_inst_d = inst_in;
            m_pc_d   = pc_in;
          end else if (in_fire) begin
            state_d  = FULL;
            s_inst_d = inst_in;
            s_pc_d   = pc_in;
          end else if (out_fire) begin
            state_d  = EMPTY;
            m_inst_d = NOP_INST;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d  = BUSY;
            m_inst_d = s_inst_q;
            m_pc_d   = s_pc_q;
          end
        end
        default: begin
          state_d  = EMPTY;
          m_inst_d = NOP_INST;
        end
      endcase
    end

    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  // State, data and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      m_inst_q    <= NOP_INST;
      m_pc_q      <= RESET_PC;
      s_inst_q    <= '0;
      s_pc_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      m_inst_q    <= m_inst_d;
      m_pc_q      <= m_pc_d;
      s_inst_q    <= s_inst_d;
      s_pc_q      <= s_pc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign inst_out  = m_inst_q;
  assign pc_out    = m_pc_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_stage_pipe_skid.sv
// Bench for stage_pipe_skid: directed scenarios plus a randomized run checked
// against a queue-based model of a two-deep FIFO stage.
module tb_stage_pipe_skid;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, out_ready;
  logic [31:0] inst_in, pc_in;
  logic        in_ready, out_valid;
  logic [31:0] inst_out, pc_out;
  logic [15:0] stall_cnt;
  logic        s_in_ready, s_out_valid;
  logic [31:0] s_inst_out, s_pc_out;
  logic [2:0]  s_stall_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  stage_pipe_skid dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_in(inst_in), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .inst_out(inst_out), .pc_out(pc_out), .stall_cnt(stall_cnt)
  );

  stage_pipe_skid #(.CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .inst_in(inst_in), .pc_in(pc_in), .flush(flush), .out_valid(s_out_valid),
    .out_ready(out_ready), .inst_out(s_inst_out), .pc_out(s_pc_out), .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return {16'hBEEF, pc[15:0]};
  endfunction

  // Drive one cycle of inputs, then return 1 time unit after the rising edge.
  task automatic cyc(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                     input logic fl, input logic ordy);
    in_valid  = iv;
    pc_in     = pc;
    inst_in   = inst;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    pc_in = '0; inst_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [65:0] got, want;
    do_reset();
    want = {1'b0, 1'b1, 32'h0, NOP};
    got  = {out_valid, in_ready, pc_out, inst_out};
    checks++;
    if (got !== want || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_init got=%h stall=%0d want=%h stall=0", got, stall_cnt, want);
    end
    // Fill to FULL, then assert reset asynchronously between edges.
    cyc(1'b1, 32'h40, ins(32'h40), 1'b0, 1'b0);
    cyc(1'b1, 32'h44, ins(32'h44), 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    want = {1'b1, 1'b0, 32'h40, ins(32'h40)};
    got  = {out_valid, in_ready, pc_out, inst_out};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_prefull got=%h want=%h", got, want);
    end
    #3 rst = 1'b1;
    #1;
    want = {1'b0, 1'b1, 32'h0, NOP};
    got  = {out_valid, in_ready, pc_out, inst_out};
    checks++;
    if (got !== want || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_async got=%h stall=%0d want=%h stall=0", got, stall_cnt, want);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    got = {out_valid, in_ready, pc_out, inst_out};
    checks++;
    if (got !== want || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_after got=%h stall=%0d want=%h stall=0", got, stall_cnt, want);
    end
  endtask

  task automatic test_streaming();
    logic [65:0] got, want;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'(4 * i), ins(32'(4 * i)), 1'b0, 1'b1);
      want = {1'b1, 1'b1, 32'(4 * i), ins(32'(4 * i))};
      got  = {out_valid, in_ready, pc_out, inst_out};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL stream_beat%0d got=%h want=%h", i, got, want);
      end
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    want = {1'b0, 1'b1, 32'hC, NOP};
    got  = {out_valid, in_ready, pc_out, inst_out};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL stream_drain got=%h want=%h", got, want);
    end
  endtask

  task automatic test_backpressure();
    logic [65:0] got;
    logic [65:0] want [5];
    want[0] = {1'b1, 1'b1, 32'h10, ins(32'h10)};
    want[1] = {1'b1, 1'b0, 32'h10, ins(32'h10)};
    want[2] = {1'b1, 1'b0, 32'h10, ins(32'h10)};
    want[3] = {1'b1, 1'b1, 32'h14, ins(32'h14)};
    want[4] = {1'b0, 1'b1, 32'h14, NOP};
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: cyc(1'b1, 32'h10, ins(32'h10), 1'b0, 1'b0);
        1: cyc(1'b1, 32'h14, ins(32'h14), 1'b0, 1'b0);
        2: cyc(1'b1, 32'h18, ins(32'h18), 1'b0, 1'b0);
        default: cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      endcase
      got = {out_valid, in_ready, pc_out, inst_out};
      checks++;
      if (got !== want[i]) begin
        errors++;
        $display("FAIL backpressure_step%0d got=%h want=%h", i, got, want[i]);
      end
    end
  endtask

  task automatic test_flush();
    logic [65:0] got;
    logic [65:0] want [7];
    want[0] = {1'b1, 1'b1, 32'h20, ins(32'h20)};
    want[1] = {1'b1, 1'b0, 32'h20, ins(32'h20)};
    want[2] = {1'b0, 1'b1, 32'h20, NOP};
    want[3] = {1'b0, 1'b1, 32'h20, NOP};
    want[4] = {1'b0, 1'b1, 32'h20, NOP};
    want[5] = {1'b1, 1'b1, 32'h30, ins(32'h30)};
    want[6] = {1'b0, 1'b1, 32'h30, NOP};
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: cyc(1'b1, 32'h20, ins(32'h20), 1'b0, 1'b0);
        1: cyc(1'b1, 32'h24, ins(32'h24), 1'b0, 1'b0);
        2: cyc(1'b1, 32'h28, ins(32'h28), 1'b1, 1'b0);
        3: cyc(1'b1, 32'h2C, ins(32'h2C), 1'b1, 1'b1);
        4: cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        5: cyc(1'b1, 32'h30, ins(32'h30), 1'b0, 1'b1);
        default: cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      endcase
      got = {out_valid, in_ready, pc_out, inst_out};
      checks++;
      if (got !== want[i]) begin
        errors++;
        $display("FAIL flush_step%0d got=%h want=%h", i, got, want[i]);
      end
    end
  endtask

  task automatic test_stall_count();
    do_reset();
    cyc(1'b1, 32'h50, ins(32'h50), 1'b0, 1'b0);
    repeat (7) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (stall_cnt !== 16'd7) begin
      errors++;
      $display("FAIL stall_7 got=%0d want=7", stall_cnt);
    end
    checks++;
    if (s_stall_cnt !== 3'd7) begin
      errors++;
      $display("FAIL stall_small_7 got=%0d want=7", s_stall_cnt);
    end
    repeat (3) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (stall_cnt !== 16'd10) begin
      errors++;
      $display("FAIL stall_10 got=%0d want=10", stall_cnt);
    end
    checks++;
    if (s_stall_cnt !== 3'd7) begin
      errors++;
      $display("FAIL stall_small_sat got=%0d want=7", s_stall_cnt);
    end
    checks++;
    if ({s_out_valid, s_in_ready, s_pc_out, s_inst_out} !== {1'b1, 1'b1, 32'h50, ins(32'h50)}) begin
      errors++;
      $display("FAIL stall_small_hold got=%b%b %h %h want=11 00000050 %h",
               s_out_valid, s_in_ready, s_pc_out, s_inst_out, ins(32'h50));
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (stall_cnt !== 16'd10 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain got=%0d v=%b want=10 v=0", stall_cnt, out_valid);
    end
  endtask

  task automatic test_random();
    ent_t        q[$];
    ent_t        e;
    logic [31:0] last_pc = 32'h0;
    logic [31:0] pcseq = 32'h1000;
    logic [15:0] exp_stall = 16'd0;
    logic [65:0] got, want;
    logic        iv, ordy, fl, exp_v, in_fire, out_fire;
    int          delivered = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      exp_v = (q.size() > 0);
      want  = {exp_v, q.size() < 2, last_pc, exp_v ? q[0].inst : NOP};
      got   = {out_valid, in_ready, pc_out, inst_out};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random_out cyc=%0d got=%h want=%h", n, got, want);
      end
      checks++;
      if (stall_cnt !== exp_stall) begin
        errors++;
        $display("FAIL random_stall cyc=%0d got=%0d want=%0d", n, stall_cnt, exp_stall);
      end
      iv     = ($urandom_range(0, 99) < 60);
      ordy   = ($urandom_range(0, 99) < 55);
      fl     = ($urandom_range(0, 99) < 5);
      e.inst = $urandom;
      e.pc   = pcseq;
      in_fire  = iv && (q.size() < 2);
      out_fire = (q.size() > 0) && ordy;
      if (q.size() > 0 && !ordy && exp_stall != 16'hFFFF) exp_stall++;
      if (out_fire) delivered++;
      if (fl) begin
        q.delete();
      end else begin
        if (out_fire) void'(q.pop_front());
        if (in_fire) q.push_back(e);
      end
      if (in_fire) pcseq += 32'd4;
      if (q.size() > 0) last_pc = q[0].pc;
      cyc(iv, e.pc, e.inst, fl, ordy);
    end
    checks++;
    if (delivered < 500) begin
      errors++;
      $display("FAIL random_activity got=%0d want>=500", delivered);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_stall_count();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
